// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - instruction-memory request/response and decode channels of the fetch stage
// master is the fetch stage side; slave is the memory/decode environment side.
interface fetch_queue_if #(
  parameter int PC_WIDTH   = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [PC_WIDTH-1:0]   imem_req_addr;
  logic                  imem_rsp_valid;
  logic [DATA_WIDTH-1:0] imem_rsp_data;
  logic                  fetch_valid;
  logic                  fetch_ready;
  logic [DATA_WIDTH-1:0] fetch_instr;
  logic [PC_WIDTH-1:0]   fetch_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output fetch_valid, fetch_instr, fetch_pc,
    input  fetch_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  fetch_valid, fetch_instr, fetch_pc,
    output fetch_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - credit-limited instruction fetch with in-order response buffer and flush
// Requests are only issued while buffered + in-flight entries fit in DEPTH, so the buffer cannot overflow.
module fetch_queue #(
  parameter int PC_WIDTH   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic                flush_i,
  output logic                pc_advance_o,
  fetch_queue_if.master       bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] stale_q, stale_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] pend_wr_q, pend_wr_d;
  logic [AW-1:0] pend_rd_q, pend_rd_d;

  logic [PC_WIDTH-1:0]   pend_pc_q   [DEPTH];
  logic [DATA_WIDTH-1:0] buf_instr_q [DEPTH];
  logic [PC_WIDTH-1:0]   buf_pc_q    [DEPTH];

  logic credit_ok;
  logic req_valid;
  logic accept;
  logic rsp_take;
  logic rsp_keep;
  logic head_valid;
  logic pop;

  always_comb begin
    credit_ok  = ({1'b0, count_q} + {1'b0, inflight_q}) < (CW+1)'(DEPTH);
    req_valid  = rst_n & ~flush_i & credit_ok;
    accept     = req_valid & bus.imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp_take   = bus.imem_rsp_valid & (inflight_q != '0);
    rsp_keep   = rsp_take & (stale_q == '0) & ~flush_i;
    head_valid = (count_q != '0);
    pop        = head_valid & bus.fetch_ready;

    inflight_d = inflight_q + CW'(accept) - CW'(rsp_take);
    pend_wr_d  = pend_wr_q + AW'(accept);
    pend_rd_d  = pend_rd_q + AW'(rsp_take);
    count_d    = count_q + CW'(rsp_keep) - CW'(pop);
    wr_ptr_d   = wr_ptr_q + AW'(rsp_keep);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    stale_d    = (rsp_take && stale_q != '0) ? stale_q - 1'b1 : stale_q;

    if (flush_i) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      // Every request still outstanding after this edge returns data nobody wants.
      stale_d  = inflight_q - CW'(rsp_take);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      inflight_q <= '0;
      stale_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pend_wr_q  <= '0;
      pend_rd_q  <= '0;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      stale_q    <= stale_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pend_wr_q  <= pend_wr_d;
      pend_rd_q  <= pend_rd_d;
    end
  end

  // Storage needs no reset: entries are only observed while count/inflight say they are live.
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_pc_q[pend_wr_q] <= pc_i;
    end
    if (rsp_keep) begin
      buf_instr_q[wr_ptr_q] <= bus.imem_rsp_data;
      buf_pc_q[wr_ptr_q]    <= pend_pc_q[pend_rd_q];
    end
  end

  assign pc_advance_o       = accept;
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_i;
  assign bus.fetch_valid    = head_valid;
  assign bus.fetch_instr    = head_valid ? buf_instr_q[rd_ptr_q] : '0;
  assign bus.fetch_pc       = head_valid ? buf_pc_q[rd_ptr_q] : '0;
endmodule
